// File: rtl/z80_io_decoder.sv
// Z80 I/O-port front end: synchronises the Z80 strobes into clk and decodes a port window.
// Define Z80_READBACK_EN to compile in the IN-cycle readback path (READ state, data_out/data_oe).
module z80_io_decoder #(
    parameter logic [7:0] BASE_ADDR = 8'h70,
    parameter int         NUM_REGS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            z80_addr,
    input  logic [7:0]            z80_data_in,
    input  logic                  z80_iorq_n,
    input  logic                  z80_wr_n,
    input  logic                  z80_rd_n,
    input  logic                  z80_m1_n,
    input  logic [8*NUM_REGS-1:0] reg_data_in,
    output logic [NUM_REGS-1:0]   write_strobe,
    output logic [7:0]            write_data,
    output logic [7:0]            z80_data_out,
    output logic                  z80_data_oe
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
`ifdef Z80_READBACK_EN
    localparam logic [1:0] ST_READ   = 2'd2;
`endif
    localparam logic [1:0] ST_WAIT   = 2'd3;

    logic [3:0]          sync1;
    logic [3:0]          sync2;
    logic [1:0]          settle;
    logic [1:0]          state;
    logic                iorq;
    logic                wr;
    logic                rd;
    logic                m1;
    logic                wr_act;
    logic                rd_act;
    logic [8:0]          diff;
    logic                hit;
    logic [2:0]          index;
    logic [NUM_REGS-1:0] strobe_onehot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '1;
            sync2  <= '1;
            settle <= 2'b00;
        end else begin
            sync1  <= {z80_iorq_n, z80_wr_n, z80_rd_n, z80_m1_n};
            sync2  <= sync1;
            settle <= {settle[0], 1'b1};
        end
    end

    assign iorq   = !sync2[3];
    assign wr     = !sync2[2];
    assign rd     = !sync2[1];
    assign m1     = !sync2[0];
    assign wr_act = iorq & wr & !m1;
    assign rd_act = iorq & rd & !m1;

    // Nine-bit difference: addresses below the base borrow into bit 8 and never hit.
    assign diff  = {1'b0, z80_addr} - {1'b0, BASE_ADDR};
    assign hit   = diff < 9'(NUM_REGS);
    assign index = diff[2:0];

    always_comb begin
        strobe_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            strobe_onehot[i] = (index == 3'(i));
        end
    end

`ifdef Z80_READBACK_EN
    logic [7:0] rd_byte;

    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (index == 3'(i)) begin
                rd_byte = reg_data_in[8*i +: 8];
            end
        end
    end
`endif

    // WAIT is held until the synchronisers have refilled after reset, so a cycle already
    // in progress at release is seen as active and discarded rather than decoded late.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_WAIT;
            write_strobe <= '0;
            write_data   <= 8'h00;
`ifdef Z80_READBACK_EN
            z80_data_out <= 8'h00;
`endif
        end else begin
            write_strobe <= '0;
            case (state)
                ST_IDLE: begin
                    if (wr_act && hit) begin
                        state        <= ST_STROBE;
                        write_strobe <= strobe_onehot;
                        write_data   <= z80_data_in;
                    end
`ifdef Z80_READBACK_EN
                    else if (rd_act && hit) begin
                        state        <= ST_READ;
                        z80_data_out <= rd_byte;
                    end
`endif
                    else if (wr_act || rd_act || (iorq && m1)) begin
                        state <= ST_WAIT;
                    end
                end
                ST_STROBE: state <= ST_WAIT;
`ifdef Z80_READBACK_EN
                ST_READ: begin
                    if (!rd_act) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                ST_WAIT: begin
                    if (settle[1] && !wr_act && !rd_act) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

`ifdef Z80_READBACK_EN
    // Raw strobes gate the pad enable so the bus is released as soon as the CPU ends the cycle.
    assign z80_data_oe = (state == ST_READ) & !z80_rd_n & !z80_iorq_n;
`else
    logic unused_reg_data;

    assign unused_reg_data = ^reg_data_in;
    assign z80_data_out    = 8'h00;
    assign z80_data_oe     = 1'b0;
`endif

endmodule

// File: tb/tb_z80_io_decoder.sv
// Directed bench for z80_io_decoder: default window instance plus a BASE_ADDR=8'hFE instance
// for the top-of-address-space boundary; readback checks follow the Z80_READBACK_EN build.
module tb_z80_io_decoder;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] ws_a;
        logic [7:0] wd_a;
        logic [3:0] ws_b;
        logic [7:0] wd_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  z80_addr;
    logic [7:0]  z80_data_in;
    logic        z80_iorq_n;
    logic        z80_wr_n;
    logic        z80_rd_n;
    logic        z80_m1_n;
    logic [31:0] reg_data_in;
    logic [3:0]  ws_a;
    logic [7:0]  wd_a;
    logic [7:0]  do_a;
    logic        oe_a;
    logic [3:0]  ws_b;
    logic [7:0]  wd_b;
    logic [7:0]  do_b;
    logic        oe_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int          pulses_a;
    int          pulses_b;
    int          oe_seen;
    int          first_cyc_a;
    int          first_cyc_b;
    logic [3:0]  first_ws_a;
    logic [3:0]  first_ws_b;
    logic [3:0]  log_ws[$];
    logic [7:0]  log_wd[$];
    vec_t        vecs[8];

    always #5 clk = ~clk;

    z80_io_decoder #(.BASE_ADDR(8'h70), .NUM_REGS(4)) dut (
        .clk(clk), .reset(reset), .z80_addr(z80_addr), .z80_data_in(z80_data_in),
        .z80_iorq_n(z80_iorq_n), .z80_wr_n(z80_wr_n), .z80_rd_n(z80_rd_n), .z80_m1_n(z80_m1_n),
        .reg_data_in(reg_data_in), .write_strobe(ws_a), .write_data(wd_a),
        .z80_data_out(do_a), .z80_data_oe(oe_a)
    );

    z80_io_decoder #(.BASE_ADDR(8'hFE), .NUM_REGS(4)) dut_top (
        .clk(clk), .reset(reset), .z80_addr(z80_addr), .z80_data_in(z80_data_in),
        .z80_iorq_n(z80_iorq_n), .z80_wr_n(z80_wr_n), .z80_rd_n(z80_rd_n), .z80_m1_n(z80_m1_n),
        .reg_data_in(reg_data_in), .write_strobe(ws_b), .write_data(wd_b),
        .z80_data_out(do_b), .z80_data_oe(oe_b)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clear_log();
        cyc         = 0;
        pulses_a    = 0;
        pulses_b    = 0;
        oe_seen     = 0;
        first_cyc_a = -1;
        first_cyc_b = -1;
        first_ws_a  = '0;
        first_ws_b  = '0;
        log_ws.delete();
        log_wd.delete();
    endtask

    // One clk period: sample just after the rising edge, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ws_a != 4'b0) begin
            if (pulses_a == 0) begin
                first_cyc_a = cyc;
                first_ws_a  = ws_a;
            end
            pulses_a++;
            log_ws.push_back(ws_a);
            log_wd.push_back(wd_a);
        end
        if (ws_b != 4'b0) begin
            if (pulses_b == 0) begin
                first_cyc_b = cyc;
                first_ws_b  = ws_b;
            end
            pulses_b++;
        end
        if (oe_a || oe_b) oe_seen++;
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [7:0] addr, input logic [7:0] data,
                                  input logic is_write, input int hold);
        clear_log();
        z80_addr    = addr;
        z80_data_in = data;
        z80_iorq_n  = 1'b0;
        if (is_write) z80_wr_n = 1'b0;
        else          z80_rd_n = 1'b0;
        repeat (hold) tick();
        z80_iorq_n = 1'b1;
        z80_wr_n   = 1'b1;
        z80_rd_n   = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int lat;

        vecs[0] = '{8'h72, 8'hA5, 4'b0100, 8'hA5, 4'b0000, 8'h00};
        vecs[1] = '{8'h74, 8'h11, 4'b0000, 8'hA5, 4'b0000, 8'h00};
        vecs[2] = '{8'h6F, 8'h22, 4'b0000, 8'hA5, 4'b0000, 8'h00};
        vecs[3] = '{8'h70, 8'h5A, 4'b0001, 8'h5A, 4'b0000, 8'h00};
        vecs[4] = '{8'h73, 8'hC3, 4'b1000, 8'hC3, 4'b0000, 8'h00};
        vecs[5] = '{8'hFE, 8'h77, 4'b0000, 8'hC3, 4'b0001, 8'h77};
        vecs[6] = '{8'hFF, 8'h88, 4'b0000, 8'hC3, 4'b0010, 8'h88};
        vecs[7] = '{8'h00, 8'h99, 4'b0000, 8'hC3, 4'b0000, 8'h88};

        // Reset asserted with an OUT cycle already on the bus.
        reset       = 1'b0;
        z80_addr    = 8'h72;
        z80_data_in = 8'hEE;
        z80_iorq_n  = 1'b0;
        z80_wr_n    = 1'b0;
        z80_rd_n    = 1'b1;
        z80_m1_n    = 1'b1;
        reg_data_in = 32'h44332211;
        repeat (3) @(negedge clk);
        check_output("reset_strobe", 32'(ws_a), 32'h0);
        check_output("reset_wdata", 32'(wd_a), 32'h0);
        check_output("reset_dout", 32'(do_a), 32'h0);
        check_output("reset_oe", 32'(oe_a), 32'h0);
        reset = 1'b1;
        clear_log();
        repeat (10) tick();
        check_output("reset_release_no_pulse", 32'(pulses_a), 32'd0);
        check_output("reset_release_wdata", 32'(wd_a), 32'h0);
        z80_iorq_n = 1'b1;
        z80_wr_n   = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].data, 1'b1, 20);
            check_output($sformatf("v%0d_strobe_a", i), 32'(first_ws_a), 32'(vecs[i].ws_a));
            check_output($sformatf("v%0d_pulses_a", i), 32'(pulses_a), (vecs[i].ws_a != 4'b0) ? 32'd1 : 32'd0);
            check_output($sformatf("v%0d_wdata_a", i), 32'(wd_a), 32'(vecs[i].wd_a));
            check_output($sformatf("v%0d_strobe_b", i), 32'(first_ws_b), 32'(vecs[i].ws_b));
            check_output($sformatf("v%0d_pulses_b", i), 32'(pulses_b), (vecs[i].ws_b != 4'b0) ? 32'd1 : 32'd0);
            check_output($sformatf("v%0d_wdata_b", i), 32'(wd_b), 32'(vecs[i].wd_b));
            if (vecs[i].ws_a != 4'b0)
                check_output($sformatf("v%0d_latency_a", i), 32'(first_cyc_a >= 1 && first_cyc_a <= 3), 32'd1);
            if (vecs[i].ws_b != 4'b0)
                check_output($sformatf("v%0d_latency_b", i), 32'(first_cyc_b >= 1 && first_cyc_b <= 3), 32'd1);
        end

        // Interrupt acknowledge at a window address.
        clear_log();
        z80_addr   = 8'h70;
        z80_iorq_n = 1'b0;
        z80_m1_n   = 1'b0;
        repeat (10) tick();
        z80_iorq_n = 1'b1;
        z80_m1_n   = 1'b1;
        repeat (4) tick();
        check_output("intack_no_pulse", 32'(pulses_a), 32'd0);
        check_output("intack_no_oe", 32'(oe_seen), 32'd0);

`ifdef Z80_READBACK_EN
        clear_log();
        lat        = -1;
        z80_addr   = 8'h73;
        z80_iorq_n = 1'b0;
        z80_rd_n   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (oe_a && lat < 0) lat = i;
        end
        check_output("read_oe_latency", 32'(lat >= 1 && lat <= 3), 32'd1);
        check_output("read_data", 32'(do_a), 32'h44);
        check_output("read_oe", 32'(oe_a), 32'd1);
        reg_data_in = 32'h99332211;
        repeat (3) tick();
        check_output("read_data_held", 32'(do_a), 32'h44);
        check_output("read_top_miss_dout", 32'(do_b), 32'h0);
        z80_rd_n = 1'b1;
        #1;
        check_output("read_oe_release", 32'(oe_a), 32'd0);
        z80_iorq_n = 1'b1;
        repeat (4) tick();
        check_output("read_no_pulse", 32'(pulses_a), 32'd0);
        reg_data_in = 32'h44332211;
        apply_stimulus(8'h70, 8'h00, 1'b0, 8);
        check_output("read70_data", 32'(do_a), 32'h11);
`else
        apply_stimulus(8'h73, 8'h00, 1'b0, 10);
        check_output("noread_oe", 32'(oe_seen), 32'd0);
        check_output("noread_dout", 32'(do_a), 32'h0);
        check_output("noread_dout_top", 32'(do_b), 32'h0);
        check_output("noread_no_pulse", 32'(pulses_a), 32'd0);
`endif

        // Back-to-back OUTs separated by a single inactive clk.
        clear_log();
        z80_addr    = 8'h70;
        z80_data_in = 8'h01;
        z80_iorq_n  = 1'b0;
        z80_wr_n    = 1'b0;
        repeat (6) tick();
        z80_iorq_n = 1'b1;
        z80_wr_n   = 1'b1;
        tick();
        z80_addr    = 8'h71;
        z80_data_in = 8'h02;
        z80_iorq_n  = 1'b0;
        z80_wr_n    = 1'b0;
        repeat (6) tick();
        z80_iorq_n = 1'b1;
        z80_wr_n   = 1'b1;
        repeat (4) tick();
        check_output("b2b_pulses", 32'(pulses_a), 32'd2);
        if (log_ws.size() >= 2) begin
            check_output("b2b_first_strobe", 32'(log_ws[0]), 32'h1);
            check_output("b2b_first_data", 32'(log_wd[0]), 32'h01);
            check_output("b2b_second_strobe", 32'(log_ws[1]), 32'h2);
            check_output("b2b_second_data", 32'(log_wd[1]), 32'h02);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_io_decoder.md
# z80_io_decoder

Z80 I/O-port front end for the register bank. Synchronises the asynchronous Z80 /IORQ, /WR, /RD and /M1 strobes into the `clk` domain and decodes the port address against a contiguous window. Each qualifying OUT cycle produces exactly one single-cycle, `clk`-aligned `write_strobe` bit plus captured data, which the downstream data registers consume directly. With readback compiled in, each qualifying IN cycle returns the selected register's contents on the Z80 data bus.

## Interface
- `BASE_ADDR`, 8'h70: first I/O port of the window.
- `NUM_REGS`, 4: number of ports/registers. Legal range 1..8.
- `clk`  in  1  high-speed (wishbone) clock; all outputs registered on its rising edge except `z80_data_oe`.
- `reset`  in  1  asynchronous, active-low reset.
- `z80_addr`  in  8  Z80 A[7:0].
- `z80_data_in`  in  8  Z80 D[7:0] as driven by the CPU.
- `z80_iorq_n`, `z80_wr_n`, `z80_rd_n`, `z80_m1_n`  in  1 each  raw Z80 control, active-low, asynchronous to `clk`.
- `reg_data_in`  in  8*NUM_REGS  flattened register contents; register i is `[8*i+7:8*i]`.
- `write_strobe`  out  NUM_REGS  one-hot, one `clk` cycle per qualifying write.
- `write_data`  out  8  data captured for the current/last write.
- `z80_data_out`  out  8  readback byte.
- `z80_data_oe`  out  1  drive enable for the Z80 data bus pads.

## Operation
- Two-flop synchroniser on each of `iorq_n`, `wr_n`, `rd_n`, `m1_n`. The FSM sees only second-stage values.
- Derived signals: `wr_act` = iorq & wr & !m1; `rd_act` = iorq & rd & !m1 (all active-true). If both are set, the cycle is treated as a write.
- Address match: `{1'b0,z80_addr} - {1'b0,BASE_ADDR}` computed 9 bits wide. Hit when the result is < NUM_REGS; no wrap at 8'hFF. Index = low 3 bits of the difference.
- FSM states:
  - IDLE:
    - `wr_act` & hit -> STROBE; capture `z80_data_in` into `write_data` and capture the index.
    - `rd_act` & hit -> READ; latch `reg_data_in[index]` into `z80_data_out`.
    - Any other active cycle (miss, or interrupt acknowledge with m1 low) -> WAIT.
  - STROBE: `write_strobe[index]` = 1 for this cycle only; -> WAIT.
  - READ: hold `z80_data_out`; -> IDLE when `rd_act` clears.
  - WAIT: -> IDLE when both `wr_act` and `rd_act` are clear.
- `z80_data_oe` = (state==READ) & !raw `z80_rd_n` & !raw `z80_iorq_n`. This gating releases the bus combinationally the moment the CPU ends the cycle.
- Reset:
  - All outputs go to 0 and `write_data`/`z80_data_out` clear to 8'h00.
  - Synchronisers preset to inactive (1).
  - FSM enters WAIT, so any Z80 cycle in progress at reset release is discarded.

## Timing
- Z80 strobe falls with setup before `clk` edge k -> stage-1 at k, stage-2 at k+1, STROBE entered at k+2. `write_strobe` is high from edge k+2 to k+3, so latency is 2–3 cycles depending on strobe phase.
- `write_data` is valid from edge k+2 and holds until the next captured write.
- One strobe per Z80 cycle regardless of cycle length. A new strobe requires `wr_act` to deassert (through the synchroniser) and reassert.
- Read: `z80_data_out` is valid at k+2 and `z80_data_oe` rises at k+2. The Z80 samples data at the end of T3; this requires clk ≥ 4× Z80 clock.
- `reg_data_in` is sampled once, on READ entry. A write landing during the read does not change the byte returned.

## Configuration
- `Z80_READBACK_EN` defined: read path as above.
- Not defined:
  - IN cycles to the window go IDLE -> WAIT.
  - `z80_data_out` and `z80_data_oe` are tied to 0.
  - `reg_data_in` is unused.
  - READ state is absent.

## Test plan
- Reset low for 3 cycles with /IORQ and /WR active, then release -> no `write_strobe` pulse. The first strobe occurs only after the cycle ends and a new OUT cycle begins.
- OUT (0x72),0xA5 with defaults, strobes held 20 clk -> exactly one pulse, `write_strobe`=4'b0100, `write_data`=8'hA5, within 3 clk of /WR falling.
- OUT (0x74),0x11 and OUT (0x6F),0x22 -> no strobe; `write_data` keeps its previous value. `BASE_ADDR`=8'hFE, `NUM_REGS`=4, OUT (0x00) -> no strobe (no wrap).
- Interrupt acknowledge (/M1 and /IORQ low, A=0x70) -> no strobe, `z80_data_oe` stays 0.
- With `Z80_READBACK_EN`, `reg_data_in`=32'h44332211, IN (0x73):
  - `z80_data_out`=8'h44 and `z80_data_oe`=1 within 3 clk.
  - `z80_data_oe`=0 in the same cycle /RD rises.
  - With the macro undefined, `z80_data_oe` never asserts.
- Back-to-back OUT (0x70),0x01 then OUT (0x71),0x02 separated by a 1-clk-wide inactive gap → two pulses, bits 0 then 1, with `write_data` 0x01 then 0x02.
